// File: rtl/systolic_mem_arbiter_pkg.sv
// Shared types and defaults for the systolic memory arbiter.
// MEM_PORT_WIDTH normally comes from header_ws.vh; a 32-bit fallback keeps this slice self-contained.
`ifndef MEM_PORT_WIDTH
`define MEM_PORT_WIDTH 32
`endif

package systolic_mem_arbiter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_t;

    localparam int DEFAULT_NUM_REQ = 3;
    // Wide enough for MEM_ACCESS_LATENCY-1 over the legal range 1..7.
    localparam int LAT_CNT_W = 3;

endpackage

// File: rtl/systolic_mem_arbiter_rr_picker.sv
// Combinational winner selection: round-robin from the slot after ptr, or lowest index
// when MEM_ARB_FIXED_PRIO_EN is defined (ptr port is then absent).
module rr_picker #(
    parameter int N = 3
`ifndef MEM_ARB_FIXED_PRIO_EN
    , parameter int PTR_W = 2
`endif
) (
    input  logic [N-1:0]     req,
`ifndef MEM_ARB_FIXED_PRIO_EN
    input  logic [PTR_W-1:0] ptr,
`endif
    output logic [N-1:0]     winner,
    output logic             any
);

    assign any = |req;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign winner = req & (~req + N'(1));
`else
    logic [N-1:0] above_ptr;
    logic [N-1:0] masked;
    logic [N-1:0] pool;

    // Prefer requesters strictly above the last winner; fall back to the full set to wrap.
    assign above_ptr = {N{1'b1}} << (32'(ptr) + 32'd1);
    assign masked    = req & above_ptr;
    assign pool      = (|masked) ? masked : req;
    assign winner    = pool & (~pool + N'(1));
`endif

endmodule

// File: rtl/systolic_mem_arbiter.sv
// Shared-RAM arbiter for the systolic array: one transaction at a time, fixed-latency memory.
// Define MEM_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module systolic_mem_arbiter
    import systolic_mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ            = DEFAULT_NUM_REQ,
    parameter int ADDR_WIDTH         = 32,
    parameter int DATA_WIDTH         = `MEM_PORT_WIDTH,
    parameter int MEM_ACCESS_LATENCY = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ-1:0]               req_wr_en,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               gnt,
    output logic [NUM_REQ-1:0]               done,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic                             mem_wr_en,
    output logic [DATA_WIDTH-1:0]            mem_wdata,
    input  logic [DATA_WIDTH-1:0]            mem_rd_data,
    output logic                             busy
);

`ifndef MEM_ARB_FIXED_PRIO_EN
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    logic [PTR_W-1:0] ptr;

    function automatic logic [PTR_W-1:0] onehot_idx(input logic [NUM_REQ-1:0] oh);
        onehot_idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (oh[i]) onehot_idx = PTR_W'(i);
    endfunction
`endif

    arb_state_t             state, state_next;
    logic [LAT_CNT_W-1:0]   cnt;
    logic [NUM_REQ-1:0]     winner;
    logic [NUM_REQ-1:0]     owner;
    logic                   any;
    logic                   is_write;
    logic                   access_last;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0]  sel_wdata;
    logic                   sel_wr_en;

    rr_picker #(
        .N     (NUM_REQ)
`ifndef MEM_ARB_FIXED_PRIO_EN
        , .PTR_W (PTR_W)
`endif
    ) u_picker (
        .req    (req),
`ifndef MEM_ARB_FIXED_PRIO_EN
        .ptr    (ptr),
`endif
        .winner (winner),
        .any    (any)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wr_en = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_addr  |= {ADDR_WIDTH{winner[i]}} & req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_wdata |= {DATA_WIDTH{winner[i]}} & req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            sel_wr_en |= winner[i] & req_wr_en[i];
        end
    end

    // The gnt cycle is the address-issue cycle; the latency count runs after it.
    assign access_last = (gnt == '0) && (cnt == '0);

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any)         state_next = ACCESS;
            ACCESS:  if (access_last) state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt       <= '0;
            done      <= '0;
            owner     <= '0;
            is_write  <= 1'b0;
            cnt       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wr_en <= 1'b0;
            rd_data   <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            ptr       <= PTR_W'(NUM_REQ - 1);
`endif
        end else begin
            gnt       <= '0;
            done      <= '0;
            mem_wr_en <= 1'b0;
            case (state)
                IDLE: if (any) begin
                    gnt       <= winner;
                    owner     <= winner;
                    mem_addr  <= sel_addr;
                    mem_wdata <= sel_wdata;
                    mem_wr_en <= sel_wr_en;
                    is_write  <= sel_wr_en;
                    cnt       <= LAT_CNT_W'(MEM_ACCESS_LATENCY - 1);
                end
                ACCESS: if (gnt == '0) begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (!is_write) rd_data <= mem_rd_data;
                        done <= owner;
`ifndef MEM_ARB_FIXED_PRIO_EN
                        ptr  <= onehot_idx(owner);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_mem_arbiter.sv
// Self-checking bench: transaction-level reference model, latency-accurate RAM, directed scenarios.
module tb_systolic_mem_arbiter;

    localparam int NREQ      = 3;
    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int LAT       = 2;
    localparam int MEM_WORDS = 256;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ-1:0]   req_wr_en = '0;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ*DW-1:0] req_wdata = '0;
    logic [NREQ-1:0]   dut_gnt, dut_done;
    logic [DW-1:0]     dut_rd_data, dut_mem_wdata, mem_rd_data;
    logic [AW-1:0]     dut_mem_addr;
    logic              dut_mem_wr_en, dut_busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    systolic_mem_arbiter #(
        .NUM_REQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_ACCESS_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_wr_en(req_wr_en),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .gnt(dut_gnt), .done(dut_done), .rd_data(dut_rd_data),
        .mem_addr(dut_mem_addr), .mem_wr_en(dut_mem_wr_en), .mem_wdata(dut_mem_wdata),
        .mem_rd_data(mem_rd_data), .busy(dut_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] init_val(input int a);
        return {24'hC0FFEE, 8'(a)};
    endfunction

    // RAM whose read data appears LAT cycles after the address is presented.
    logic [DW-1:0] ram [MEM_WORDS];
    logic [DW-1:0] pipe [LAT];
    assign mem_rd_data = pipe[LAT-1];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int a = 0; a < MEM_WORDS; a++) ram[a] <= init_val(a);
            for (int k = 0; k < LAT; k++) pipe[k] <= '0;
        end else begin
            if (dut_mem_wr_en) ram[dut_mem_addr[7:0]] <= dut_mem_wdata;
            pipe[0] <= ram[dut_mem_addr[7:0]];
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end
    end

    // Reference model: a transaction occupies the grant edge plus LAT+1 more edges.
    function automatic int pick(input logic [NREQ-1:0] r, input int last);
`ifdef MEM_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) if (r[i]) return i;
`else
        for (int k = 1; k <= NREQ; k++) if (r[(last + k) % NREQ]) return (last + k) % NREQ;
`endif
        return -1;
    endfunction

    logic [DW-1:0]   ref_mem [MEM_WORDS];
    int              m_age, m_ptr, m_w, m_pick;
    logic            m_wr;
    logic [NREQ-1:0] e_gnt, e_done;
    logic            e_wr_en, e_busy;
    logic [AW-1:0]   e_addr;
    logic [DW-1:0]   e_wdata, e_rd;

    always_comb m_pick = pick(req, m_ptr);
    assign e_busy = (m_age >= 0);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_age <= -1; m_ptr <= NREQ - 1; m_w <= 0; m_wr <= 1'b0;
            e_gnt <= '0; e_done <= '0; e_wr_en <= 1'b0;
            e_addr <= '0; e_wdata <= '0; e_rd <= '0;
            for (int a = 0; a < MEM_WORDS; a++) ref_mem[a] <= init_val(a);
        end else begin
            e_gnt <= '0; e_done <= '0; e_wr_en <= 1'b0;
            if (m_age < 0) begin
                if (m_pick >= 0) begin
                    e_gnt   <= NREQ'(1 << m_pick);
                    m_age   <= 0;
                    m_w     <= m_pick;
                    m_wr    <= req_wr_en[m_pick];
                    e_wr_en <= req_wr_en[m_pick];
                    e_addr  <= req_addr[m_pick*AW +: AW];
                    e_wdata <= req_wdata[m_pick*DW +: DW];
                    if (req_wr_en[m_pick])
                        ref_mem[req_addr[m_pick*AW +: 8]] <= req_wdata[m_pick*DW +: DW];
                end
            end else if (m_age == LAT) begin
                e_done <= NREQ'(1 << m_w);
                if (!m_wr) e_rd <= ref_mem[e_addr[7:0]];
                m_ptr <= m_w;
                m_age <= -1;
            end else begin
                m_age <= m_age + 1;
            end
        end
    end

    // Per-cycle comparison plus event logs for the directed scenarios.
    int            g_cyc[$], g_idx[$], d_cyc[$], d_idx[$];
    logic [AW-1:0] g_addr[$];
    logic [DW-1:0] d_rd[$];
    int            wr_cycles = 0;

    always @(negedge clk) begin
        check("gnt", dut_gnt, e_gnt);
        check("done", dut_done, e_done);
        check("busy", dut_busy, e_busy);
        check("mem_wr_en", dut_mem_wr_en, e_wr_en);
        check("mem_addr", dut_mem_addr, e_addr);
        check("mem_wdata", dut_mem_wdata, e_wdata);
        check("rd_data", dut_rd_data, e_rd);
        check("gnt_done_onehot", ($countones(dut_gnt) <= 1) && ($countones(dut_done) <= 1), 1);
        if (dut_gnt != '0) begin
            g_cyc.push_back(cyc); g_idx.push_back($clog2(dut_gnt)); g_addr.push_back(dut_mem_addr);
        end
        if (dut_done != '0) begin
            d_cyc.push_back(cyc); d_idx.push_back($clog2(dut_done)); d_rd.push_back(dut_rd_data);
        end
        if (dut_mem_wr_en) wr_cycles++;
    end

    task automatic clear_logs();
        g_cyc.delete(); g_idx.delete(); g_addr.delete();
        d_cyc.delete(); d_idx.delete(); d_rd.delete();
        wr_cycles = 0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Hold a request until its grant is seen (bounded), then drop it.
    task automatic issue(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit seen;
        seen = 1'b0;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
        req_wr_en[i] = wr;
        req[i]       = 1'b1;
        for (int k = 0; k < 16 && !seen; k++) begin
            @(negedge clk);
            if (dut_gnt[i]) seen = 1'b1;
        end
        req[i] = 1'b0;
        check("issue_gnt_seen", seen, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, rel, n;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", dut_busy, 0);
        check("rst_gnt", dut_gnt, 0);
        check("rst_mem_addr", dut_mem_addr, 0);
        check("rst_rd_data", dut_rd_data, 0);
        rst = 1'b1;
        @(negedge clk);

        // Single read from requester 0 at 0x10.
        clear_logs();
        c0 = cyc;
        issue(0, 1'b0, 32'h10, 32'h0);
        repeat (6) @(negedge clk);
        check("s1_gnt_count", g_idx.size(), 1);
        check("s1_done_count", d_idx.size(), 1);
        if (g_idx.size() >= 1) begin
            check("s1_gnt_cycle", g_cyc[0] - c0, 1);
            check("s1_gnt_idx", g_idx[0], 0);
            check("s1_mem_addr", g_addr[0], 32'h10);
        end
        if (d_idx.size() >= 1) begin
            check("s1_done_cycle", d_cyc[0] - c0, 4);
            check("s1_rd_data", d_rd[0], 32'hC0FFEE10);
        end

        // All three held high from a fresh pointer.
        do_reset();
        clear_logs();
        c0 = cyc;
        req_addr = {32'h13, 32'h12, 32'h11};
        req_wr_en = '0;
        req = 3'b111;
        repeat (14) @(negedge clk);
        req = '0;
        repeat (6) @(negedge clk);
        check("s2_gnt_count", g_idx.size(), 4);
        if (g_idx.size() == 4) begin
            check("s2_order0", g_idx[0], 0);
            check("s2_order1", g_idx[1], 1);
            check("s2_order2", g_idx[2], 2);
            check("s2_order3", g_idx[3], 0);
            check("s2_t0", g_cyc[0] - c0, 1);
            check("s2_t1", g_cyc[1] - c0, 5);
            check("s2_t2", g_cyc[2] - c0, 9);
            check("s2_t3", g_cyc[3] - c0, 13);
        end

        // Write from requester 2, then read back.
        clear_logs();
        issue(2, 1'b1, 32'h20, 32'hBEEF);
        repeat (6) @(negedge clk);
        check("s3_wr_en_cycles", wr_cycles, 1);
        check("s3_done_count", d_idx.size(), 1);
        if (d_idx.size() >= 1) check("s3_done_idx", d_idx[0], 2);
        clear_logs();
        issue(0, 1'b0, 32'h20, 32'h0);
        repeat (6) @(negedge clk);
        check("s3_rb_count", d_rd.size(), 1);
        if (d_rd.size() >= 1) check("s3_readback", d_rd[0], 32'hBEEF);

        // Reset in the middle of an access.
        clear_logs();
        issue(0, 1'b0, 32'h30, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        req_addr[AW +: AW] = 32'h31;
        req_wr_en[1] = 1'b0;
        req[1] = 1'b1;
        #1;
        check("s4_rst_gnt", dut_gnt, 0);
        check("s4_rst_done", dut_done, 0);
        check("s4_rst_busy", dut_busy, 0);
        check("s4_rst_addr", dut_mem_addr, 0);
        check("s4_rst_wdata", dut_mem_wdata, 0);
        check("s4_rst_wr_en", dut_mem_wr_en, 0);
        check("s4_rst_rd_data", dut_rd_data, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        rel = cyc;
        repeat (2) @(negedge clk);
        req[1] = 1'b0;
        check("s4_no_done", d_idx.size(), 0);
        n = g_idx.size();
        check("s4_gnt_count", n, 2);
        if (n == 2) begin
            check("s4_gnt1_idx", g_idx[1], 1);
            check("s4_gnt1_cycle", g_cyc[1] - rel, 1);
        end
        repeat (6) @(negedge clk);

        // Request withdrawn one cycle before it would have been granted.
        clear_logs();
        c0 = cyc;
        req_addr[0 +: AW] = 32'h40;
        req_wr_en = '0;
        req[0] = 1'b1;
        @(negedge clk);
        req[0] = 1'b0;
        @(negedge clk);
        req_addr[AW +: AW] = 32'h41;
        req[1] = 1'b1;
        repeat (2) @(negedge clk);
        req[1] = 1'b0;
        @(negedge clk);
        check("s5_busy_low", dut_busy, 0);
        repeat (4) @(negedge clk);
        check("s5_busy_still_low", dut_busy, 0);
        check("s5_gnt_count", g_idx.size(), 1);
        if (g_idx.size() >= 1) begin
            check("s5_gnt_idx", g_idx[0], 0);
            check("s5_gnt_cycle", g_cyc[0] - c0, 1);
        end

        // Requesters 0 and 2 held high: priority behaviour at the wrap boundary.
        do_reset();
        clear_logs();
        req_addr = {32'h52, 32'h51, 32'h50};
        req_wr_en = '0;
        req = 3'b101;
        repeat (14) @(negedge clk);
        req = '0;
        repeat (6) @(negedge clk);
        check("s6_gnt_count", g_idx.size(), 4);
        if (g_idx.size() == 4) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            check("s6_fixed0", g_idx[0], 0);
            check("s6_fixed1", g_idx[1], 0);
            check("s6_fixed2", g_idx[2], 0);
            check("s6_fixed3", g_idx[3], 0);
`else
            check("s6_rr0", g_idx[0], 0);
            check("s6_rr1", g_idx[1], 2);
            check("s6_rr2", g_idx[2], 0);
            check("s6_rr3", g_idx[3], 2);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/systolic_mem_arbiter.md
SYSTOLIC_MEM_ARBITER -- requirements
Module: systolic_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, number of requesters (0 = matmul FSM, 1 = STW/BIST engine, 2 = output writer).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, memory address width.
REQ-003 SHALL have parameter DATA_WIDTH, default `MEM_PORT_WIDTH, memory data width.
REQ-004 SHALL have parameter MEM_ACCESS_LATENCY, default 2, clock cycles from address issue to valid mem_rd_data (legal range 1..7).
REQ-005 SHALL have port clk, input, 1, single clock; all flops on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports req / req_wr_en, input, NUM_REQ each, per-requester request and write flag.
REQ-008 SHALL have ports req_addr / req_wdata, input, NUM_REQ*ADDR_WIDTH / NUM_REQ*DATA_WIDTH, packed per requester (requester i at slice i).
REQ-009 SHALL have port gnt, output, NUM_REQ, one-hot grant pulse.
REQ-010 SHALL have port done, output, NUM_REQ, one-hot completion pulse.
REQ-011 SHALL have port rd_data, output, DATA_WIDTH, read data, valid while the done bit of a read is high.
REQ-012 SHALL have ports mem_addr (ADDR_WIDTH), mem_wr_en (1), mem_wdata (DATA_WIDTH), outputs to RAM; mem_rd_data, input, DATA_WIDTH.
REQ-013 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE and ACCESS.
REQ-015 In IDLE with any req bit high, the arbiter SHALL select winner w at the clock edge, then pulse gnt[w] for exactly 1 cycle, register mem_addr/mem_wdata from slice w, drive mem_wr_en = req_wr_en[w] for exactly 1 cycle, load the latency counter with MEM_ACCESS_LATENCY-1, and enter ACCESS.
REQ-016 In ACCESS with counter != 0, the arbiter SHALL decrement the counter.
REQ-017 In ACCESS with counter == 0, the arbiter SHALL register rd_data <= mem_rd_data (reads only; rd_data holds its value for writes), pulse done[w] for 1 cycle, advance the priority pointer, and return to IDLE.
REQ-018 Round-robin priority SHALL be searched starting at the index after the last winner, wrapping from NUM_REQ-1 to 0; the pointer SHALL reset to NUM_REQ-1, so requester 0 wins first.
REQ-019 Requests SHALL be sampled only in IDLE; a requester SHALL hold req, addr, wr_en and wdata until its gnt pulse, and a req dropped before grant SHALL be ignored.
REQ-020 mem_addr SHALL hold its value through ACCESS; gnt and done SHALL never have more than one bit set.
REQ-021 Transaction spacing SHALL be MEM_ACCESS_LATENCY+2 cycles from one grant to the next grant.
REQ-022 A requester whose req stays high after its own done SHALL be re-arbitrated normally, with no implicit retention of the grant.

Reset
REQ-023 While rst is low, the block SHALL hold state=IDLE, gnt=0, done=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, rd_data=0, counter=0, pointer=NUM_REQ-1 and busy=0.
REQ-024 Reset asserted mid-ACCESS SHALL abort the transaction with no done pulse; the first arbitration SHALL occur on the first edge after deassertion.

Configuration
REQ-025 When MEM_ARB_FIXED_PRIO_EN is defined, arbitration SHALL use fixed priority with the lowest index winning, and the pointer SHALL be absent.
REQ-026 When MEM_ARB_FIXED_PRIO_EN is undefined, arbitration SHALL be round-robin per REQ-018.

Structure
REQ-027 The shared package SHALL hold the arb_state_t enum (IDLE, ACCESS) and the default NUM_REQ constant; base addresses and MEM_ADDR_INCR SHALL remain in header_ws.vh.
REQ-028 Winner selection SHALL be a combinational sub-module rr_picker taking req and pointer and producing a one-hot winner plus an any flag.

Verification
REQ-029 Scenario: single read, req[0] with addr 0x10 at cycle 0 and LAT=2 -> gnt[0] at cycle 1, mem_addr=0x10, done[0] at cycle 4, rd_data equals RAM[0x10].
REQ-030 Scenario: all three requesters held high -> grant order 0,1,2,0, with grants 4 cycles apart.
REQ-031 Scenario: write from req[2] with wdata 0xBEEF to addr 0x20 -> mem_wr_en high for exactly 1 cycle, and a later read of 0x20 returns 0xBEEF.
REQ-032 Scenario: rst pulled low during ACCESS -> no done pulse, all outputs 0, and after release req[1] is granted on the first edge.
REQ-033 Scenario: MEM_ARB_FIXED_PRIO_EN defined with req[0] and req[2] held high -> req[0] is granted every time and req[2] is never granted.
REQ-034 Scenario: req[1] dropped one cycle before its expected grant -> no gnt[1] is issued and busy stays low.
